// File: rtl/mfp_ahb_lite_master_pkg.sv
// Shared AHB-Lite encodings used by the single-transfer master and its bench.
package mfp_ahb_lite_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/mfp_ahb_lite_master_rsp_reg.sv
// Response holding register with valid/ready; a one-entry skid catches the
// completion of a transfer already in flight when the consumer stalls.
module mfp_ahb_lite_master_rsp_reg (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_rdata,
  input  logic        i_err,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic        r_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_sk_valid;
  logic [31:0] r_sk_rdata;
  logic        r_sk_err;
  logic        w_free;

  assign w_free  = ~r_valid | i_ready;
  assign o_valid = r_valid;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
      r_sk_valid <= 1'b0;
      r_sk_rdata <= 32'h0;
      r_sk_err   <= 1'b0;
    end else if (w_free) begin
      if (r_sk_valid) begin
        r_valid    <= 1'b1;
        r_rdata    <= r_sk_rdata;
        r_err      <= r_sk_err;
        r_sk_valid <= i_load;
        if (i_load) begin
          r_sk_rdata <= i_rdata;
          r_sk_err   <= i_err;
        end
      end else begin
        r_valid <= i_load;
        if (i_load) begin
          r_rdata <= i_rdata;
          r_err   <= i_err;
        end
      end
    end else if (i_load) begin
      r_sk_valid <= 1'b1;
      r_sk_rdata <= i_rdata;
      r_sk_err   <= i_err;
    end
  end

endmodule

// File: rtl/mfp_ahb_lite_master.sv
// AHB-Lite single-transfer master: command in, pipelined address/data phases,
// one response per command including two-cycle error handling.
module mfp_ahb_lite_master
  import mfp_ahb_lite_master_pkg::*;
#(
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR} state_e;

  state_e      r_state;
  logic [31:0] r_haddr;
  logic [31:0] r_hwdata;
  logic        r_hwrite;
  logic [2:0]  r_hsize;
  logic        w_accept;
  logic        w_rsp_block;
  logic        w_rsp_load;
  logic        w_rsp_err;
  logic [31:0] w_rsp_rdata;

  assign w_rsp_block = rsp_valid & ~rsp_ready;
  assign cmd_ready   = ~HRESET & HREADY & ~w_rsp_block & (r_state != S_ERR);
  assign w_accept    = cmd_valid & cmd_ready;

  assign HTRANS    = w_accept ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = w_accept ? cmd_addr  : r_haddr;
  assign HWRITE    = w_accept ? cmd_write : r_hwrite;
  assign HSIZE     = w_accept ? cmd_size  : r_hsize;
  assign HWDATA    = r_hwdata;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;
  assign HPROT     = HPROT_VALUE;

  // r_hwrite doubles as the direction of the outstanding data phase.
  assign w_rsp_load  = ~HRESET & HREADY & ((r_state == S_DATA) | (r_state == S_ERR));
  assign w_rsp_err   = (r_state == S_ERR) | HRESP;
  assign w_rsp_rdata = (w_rsp_err | r_hwrite) ? 32'h0 : HRDATA;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state  <= S_IDLE;
      r_haddr  <= 32'h0;
      r_hwdata <= 32'h0;
      r_hwrite <= 1'b0;
      r_hsize  <= HSIZE_WORD;
    end else begin
      if (w_accept) begin
        r_haddr  <= cmd_addr;
        r_hwdata <= cmd_wdata;
        r_hwrite <= cmd_write;
        r_hsize  <= cmd_size;
      end
      case (r_state)
        S_IDLE: if (w_accept) r_state <= S_DATA;
        S_DATA: begin
          if (HREADY) r_state <= w_accept ? S_DATA : S_IDLE;
          else if (HRESP) r_state <= S_ERR;
        end
        S_ERR:   if (HREADY) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  mfp_ahb_lite_master_rsp_reg u_rsp_reg (
    .i_clk   (HCLK),
    .i_rst   (HRESET),
    .i_load  (w_rsp_load),
    .i_rdata (w_rsp_rdata),
    .i_err   (w_rsp_err),
    .i_ready (rsp_ready),
    .o_valid (rsp_valid),
    .o_rdata (rsp_rdata),
    .o_err   (rsp_err)
  );

endmodule

// File: tb/tb_mfp_ahb_lite_master.sv
// Directed bench for mfp_ahb_lite_master: single-transfer table plus
// hand-written pipelining, wait-state, error, backpressure and reset sequences.
module tb_mfp_ahb_lite_master;
  import mfp_ahb_lite_master_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [2:0]  cmd_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HBURST, HSIZE;
  logic        HMASTLOCK, HWRITE, HREADY, HRESP;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_lite_master #(.HPROT_VALUE(4'b0011)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge, outputs checked 1 unit later.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic cmd(input logic v, input logic wr, input logic [31:0] a,
                     input logic [2:0] sz, input logic [31:0] wd);
    cmd_valid = v; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
  endtask

  task automatic chk_rsp(input string name, input logic v, input logic [31:0] rd, input logic e);
    chk({name, ".valid"}, 32'(rsp_valid), 32'(v));
    if (v) begin
      chk({name, ".rdata"}, rsp_rdata, rd);
      chk({name, ".err"}, 32'(rsp_err), 32'(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h1f80_0000, 3'd2, 32'h0000_00A5, 32'h1234_5678, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0100, 3'd2, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 32'h0000_0203, 3'd0, 32'h0,         32'h0000_00C3, 32'h0000_00C3};
    vecs[3] = '{1'b1, 32'h8000_0010, 3'd1, 32'h5A5A_0000, 32'hFFFF_FFFF, 32'h0};

    // Reset, with a request and a ready slave present to prove cmd_ready is held low.
    HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0; rsp_ready = 1'b1;
    cmd(1'b1, 1'b1, 32'hFFFF_FFF0, 3'd0, 32'hFFFF_FFFF);
    tick(); tick(); settle();
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst.HTRANS", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("rst.HADDR", HADDR, 32'h0);
    chk("rst.HWDATA", HWDATA, 32'h0);
    chk("rst.HWRITE", 32'(HWRITE), 32'd0);
    chk("rst.HSIZE", 32'(HSIZE), 32'd2);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    chk("rst.HBURST", 32'(HBURST), 32'd0);
    chk("rst.HMASTLOCK", 32'(HMASTLOCK), 32'd0);
    chk("rst.HPROT", 32'(HPROT), 32'h3);
    cmd(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
    tick(); HRESET = 1'b0;

    // Isolated zero-wait transfers: NONSEQ on accept, HWDATA next, response 2 cycles after.
    for (int i = 0; i < 4; i++) begin
      tick();
      cmd(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata);
      settle();
      chk("vec.cmd_ready", 32'(cmd_ready), 32'd1);
      chk("vec.HTRANS", 32'(HTRANS), 32'(HTRANS_NONSEQ));
      chk("vec.HADDR", HADDR, vecs[i].addr);
      chk("vec.HWRITE", 32'(HWRITE), 32'(vecs[i].wr));
      chk("vec.HSIZE", 32'(HSIZE), 32'(vecs[i].size));
      tick();
      cmd(1'b0, 1'b0, 32'h0, 3'd2, 32'h0);
      HRDATA = vecs[i].hrdata;
      settle();
      chk("vec.dp.HTRANS", 32'(HTRANS), 32'(HTRANS_IDLE));
      chk("vec.dp.HADDR_hold", HADDR, vecs[i].addr);
      if (vecs[i].wr) chk("vec.dp.HWDATA", HWDATA, vecs[i].wdata);
      chk("vec.dp.rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      HRDATA = 32'h0BAD_0BAD;
      settle();
      chk_rsp("vec.rsp", 1'b1, vecs[i].exp_rdata, 1'b0);
      tick(); settle();
      chk("vec.rsp_popped", 32'(rsp_valid), 32'd0);
    end

    // Three back-to-back reads at zero wait states.
    tick(); cmd(1'b1, 1'b0, 32'h0, 3'd2, 32'h0); settle();
    chk("b2b.0.HTRANS", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("b2b.0.HADDR", HADDR, 32'h0);
    tick(); cmd(1'b1, 1'b0, 32'h4, 3'd2, 32'h0); HRDATA = 32'h1111_1111; settle();
    chk("b2b.1.HTRANS", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("b2b.1.HADDR", HADDR, 32'h4);
    tick(); cmd(1'b1, 1'b0, 32'h8, 3'd2, 32'h0); HRDATA = 32'h2222_2222; settle();
    chk("b2b.2.HTRANS", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("b2b.2.HADDR", HADDR, 32'h8);
    chk_rsp("b2b.rsp0", 1'b1, 32'h1111_1111, 1'b0);
    tick(); cmd(1'b0, 1'b0, 32'h0, 3'd2, 32'h0); HRDATA = 32'h3333_3333; settle();
    chk("b2b.3.HTRANS", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk_rsp("b2b.rsp1", 1'b1, 32'h2222_2222, 1'b0);
    tick(); settle();
    chk_rsp("b2b.rsp2", 1'b1, 32'h3333_3333, 1'b0);
    tick(); settle();
    chk("b2b.done", 32'(rsp_valid), 32'd0);

    // Write with 3 wait states and a read queued behind it.
    tick(); cmd(1'b1, 1'b1, 32'h40, 3'd2, 32'hCAFE_F00D); settle();
    chk("ws.accept", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    for (int w = 0; w < 3; w++) begin
      tick(); cmd(1'b1, 1'b0, 32'h80, 3'd2, 32'h0); HREADY = 1'b0; settle();
      chk("ws.cmd_ready", 32'(cmd_ready), 32'd0);
      chk("ws.HTRANS", 32'(HTRANS), 32'(HTRANS_IDLE));
      chk("ws.HWDATA", HWDATA, 32'hCAFE_F00D);
      chk("ws.HADDR", HADDR, 32'h40);
      chk("ws.rsp_valid", 32'(rsp_valid), 32'd0);
    end
    tick(); HREADY = 1'b1; settle();
    chk("ws.next.HTRANS", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("ws.next.HADDR", HADDR, 32'h80);
    chk("ws.next.HWDATA", HWDATA, 32'hCAFE_F00D);
    tick(); cmd(1'b0, 1'b0, 32'h0, 3'd2, 32'h0); HRDATA = 32'h55AA_55AA; settle();
    chk_rsp("ws.rsp_wr", 1'b1, 32'h0, 1'b0);
    tick(); settle();
    chk_rsp("ws.rsp_rd", 1'b1, 32'h55AA_55AA, 1'b0);
    tick(); settle();
    chk("ws.done", 32'(rsp_valid), 32'd0);

    // Two-cycle error response with a queued command.
    tick(); cmd(1'b1, 1'b0, 32'hF000_0000, 3'd2, 32'h0); settle();
    chk("err.accept", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    tick(); cmd(1'b1, 1'b0, 32'h10, 3'd2, 32'h0); HREADY = 1'b0; HRESP = 1'b1; settle();
    chk("err.c1.HTRANS", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("err.c1.cmd_ready", 32'(cmd_ready), 32'd0);
    tick(); HREADY = 1'b1; HRESP = 1'b1; HRDATA = 32'hBEEF_BEEF; settle();
    chk("err.c2.HTRANS", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("err.c2.cmd_ready", 32'(cmd_ready), 32'd0);
    tick(); HRESP = 1'b0; settle();
    chk_rsp("err.rsp", 1'b1, 32'h0, 1'b1);
    chk("err.requeue.HTRANS", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("err.requeue.HADDR", HADDR, 32'h10);
    tick(); cmd(1'b0, 1'b0, 32'h0, 3'd2, 32'h0); HRDATA = 32'h0000_0077; settle();
    chk("err.gap", 32'(rsp_valid), 32'd0);
    tick(); settle();
    chk_rsp("err.rsp_next", 1'b1, 32'h0000_0077, 1'b0);
    tick(); settle();
    chk("err.done", 32'(rsp_valid), 32'd0);

    // Response backpressure for 5 cycles with a request waiting.
    tick(); cmd(1'b1, 1'b0, 32'h200, 3'd2, 32'h0); rsp_ready = 1'b0; settle();
    chk("bp.accept", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    tick(); cmd(1'b0, 1'b0, 32'h0, 3'd2, 32'h0); HRDATA = 32'h1234_5678; settle();
    for (int c = 0; c < 5; c++) begin
      tick(); cmd(1'b1, 1'b0, 32'h300, 3'd2, 32'h0); HRDATA = 32'(c) + 32'hA000_0000; settle();
      chk("bp.cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp.HTRANS", 32'(HTRANS), 32'(HTRANS_IDLE));
      chk_rsp("bp.rsp", 1'b1, 32'h1234_5678, 1'b0);
    end
    tick(); rsp_ready = 1'b1; settle();
    chk_rsp("bp.release", 1'b1, 32'h1234_5678, 1'b0);
    chk("bp.release.HTRANS", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    chk("bp.release.HADDR", HADDR, 32'h300);
    tick(); cmd(1'b0, 1'b0, 32'h0, 3'd2, 32'h0); HRDATA = 32'h0000_0009; settle();
    chk("bp.gap", 32'(rsp_valid), 32'd0);
    tick(); settle();
    chk_rsp("bp.rsp_next", 1'b1, 32'h0000_0009, 1'b0);

    // Stall arriving while a second transfer is already in its data phase.
    tick(); cmd(1'b1, 1'b0, 32'h400, 3'd2, 32'h0); settle();
    tick(); cmd(1'b1, 1'b0, 32'h404, 3'd2, 32'h0); HRDATA = 32'h0000_000A; settle();
    chk("sk.second.HTRANS", 32'(HTRANS), 32'(HTRANS_NONSEQ));
    tick(); cmd(1'b0, 1'b0, 32'h0, 3'd2, 32'h0); HRDATA = 32'h0000_000B; rsp_ready = 1'b0; settle();
    chk_rsp("sk.hold0", 1'b1, 32'h0000_000A, 1'b0);
    chk("sk.cmd_ready", 32'(cmd_ready), 32'd0);
    tick(); HRDATA = 32'h0; settle();
    chk_rsp("sk.hold1", 1'b1, 32'h0000_000A, 1'b0);
    tick(); rsp_ready = 1'b1; settle();
    chk_rsp("sk.first", 1'b1, 32'h0000_000A, 1'b0);
    tick(); settle();
    chk_rsp("sk.second", 1'b1, 32'h0000_000B, 1'b0);
    tick(); settle();
    chk("sk.done", 32'(rsp_valid), 32'd0);

    // Reset during a wait state abandons the transfer.
    tick(); cmd(1'b1, 1'b1, 32'h500, 3'd0, 32'hFFFF_0000); settle();
    tick(); cmd(1'b0, 1'b0, 32'h0, 3'd2, 32'h0); HREADY = 1'b0; HRESET = 1'b1; settle();
    chk("rstw.cmd_ready", 32'(cmd_ready), 32'd0);
    tick(); HRESET = 1'b0; HREADY = 1'b1; settle();
    chk("rstw.HTRANS", 32'(HTRANS), 32'(HTRANS_IDLE));
    chk("rstw.HADDR", HADDR, 32'h0);
    chk("rstw.HWDATA", HWDATA, 32'h0);
    chk("rstw.HWRITE", 32'(HWRITE), 32'd0);
    chk("rstw.HSIZE", 32'(HSIZE), 32'd2);
    chk("rstw.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstw.rsp_rdata", rsp_rdata, 32'h0);
    tick(); settle();
    chk("rstw.no_rsp1", 32'(rsp_valid), 32'd0);
    tick(); settle();
    chk("rstw.no_rsp2", 32'(rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
